// File: rtl/spad_pkg.sv
// Shared constants, pixel-word field positions and FSM state types for the
// SPAD frame accumulator.
package spad_pkg;

  localparam int NPIX = 512;
  localparam int SUMW = 13;
  localparam int WORDW = 16;
  localparam logic [3:0] HDR_TAG = 4'hF;

  localparam int PIX_ADDR_MSB = 15;
  localparam int PIX_ADDR_LSB = 6;
  localparam int PIX_CNT_MSB = 4;
  localparam int PIX_CNT_LSB = 0;

  typedef enum logic {
    ACC_IDLE,
    ACC_RUN
  } acc_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_HDR,
    D_DATA
  } dmp_state_e;

  typedef struct packed {
    acc_state_e acc;
    dmp_state_e dmp;
    logic       bank;
  } spad_dbg_t;

endpackage

// File: rtl/spad_accum_ram.sv
// Simple dual-port accumulation RAM: port A read/write for the accumulator,
// port B read-only for the dumper, both with a 1-cycle synchronous read.
module spad_accum_ram #(
  parameter int DEPTH = 1024,
  parameter int W = 13,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [W-1:0]  a_wdata,
  input  logic [AW-1:0] a_raddr,
  output logic [W-1:0]  a_rdata,
  input  logic [AW-1:0] b_raddr,
  output logic [W-1:0]  b_rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    a_rdata <= mem[a_raddr];
    b_rdata <= mem[b_raddr];
  end

endmodule

// File: rtl/spad_frame_accum.sv
// Accumulates masked per-pixel counts over N readout frames into a ping-pong
// RAM and streams each completed set (header first) to the host FIFO.
module spad_frame_accum
  import spad_pkg::*;
#(
  parameter int NPIX = spad_pkg::NPIX,
  parameter int SUMW = spad_pkg::SUMW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  frames_per_out,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  input  logic        mask_we,
  input  logic [8:0]  mask_addr,
  input  logic        mask_bit,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        ovf_err,
  output logic        seq_err,
  input  logic        clr_err,
  output spad_dbg_t   dbg
);

  localparam int PAW = $clog2(NPIX);
  localparam int RAW = PAW + 1;

  acc_state_e          acc_state;
  dmp_state_e          d_state;
  logic                bank;
  logic                d_bank;
  logic [PAW-1:0]      exp_addr;
  logic [7:0]          frame_cnt;
  logic [7:0]          n_lat;
  logic [NPIX-1:0]     mask_q;
  logic                prev_valid;
  logic                wr_pend;
  logic [PAW-1:0]      wr_addr;
  logic [4:0]          wr_cnt;
  logic                wr_first;
  logic                wr_last;
  logic [PAW:0]        rd_ptr;
  logic [PAW-1:0]      tx_cnt;
  logic                rd_inflight;
  logic                pf_valid;
  logic [WORDW-1:0]    pf_data;
  logic [11:0]         set_cnt;
  logic [SUMW-1:0]     ram_a_rdata;
  logic [SUMW-1:0]     ram_b_rdata;

  logic [9:0]          pix_addr;
  logic [4:0]          pix_cnt;
  logic [PAW-1:0]      pix_idx;
  logic                pix_oor;
  logic                pix_take;
  logic                pix_bad;
  logic                pix_unused;
  logic [7:0]          n_eff;
  logic [SUMW-1:0]     wr_sum;
  logic                set_done;
  logic                fire;
  logic                dump_done;
  logic                dmp_free;
  logic                dump_start;
  logic                set_drop;
  logic [1:0]          held_next;
  logic                rd_issue;
  logic [RAW-1:0]      b_raddr;
  logic [WORDW-1:0]    rd_word;
  logic                load_out;

  assign pix_addr   = pix_data[PIX_ADDR_MSB:PIX_ADDR_LSB];
  assign pix_cnt    = pix_data[PIX_CNT_MSB:PIX_CNT_LSB];
  assign pix_unused = pix_data[5];
  assign pix_idx    = pix_addr[PAW-1:0];
  assign pix_oor    = 32'(pix_addr) >= NPIX;
  assign n_eff      = (frames_per_out == 8'd0) ? 8'd1 : frames_per_out;

  // addr 0 is always accepted: it restarts the current frame (resync)
  assign pix_take = (acc_state == ACC_RUN) && en && pix_valid && !prev_valid && !pix_oor &&
                    ((pix_idx == exp_addr) || (pix_idx == '0));
  assign pix_bad  = (acc_state == ACC_RUN) && en && pix_valid && !pix_take;

  assign wr_sum   = wr_first ? SUMW'(wr_cnt) : ram_a_rdata + SUMW'(wr_cnt);
  assign set_done = wr_pend && wr_last && (frame_cnt + 8'd1 == n_lat);

  // Stream handshake: a word moves when out_valid && out_ready; while
  // out_valid && !out_ready, out_data is held and out_valid stays high.
  assign fire       = out_valid && out_ready;
  assign dump_done  = (d_state == D_DATA) && fire && (tx_cnt == PAW'(NPIX - 1));
  assign dmp_free   = (d_state == D_IDLE) || dump_done;
  assign dump_start = set_done && dmp_free;
  assign set_drop   = set_done && !dmp_free;

  // Only issue a read if its data is guaranteed a slot (out or prefetch) next cycle
  assign held_next = 2'(out_valid) + 2'(pf_valid) + 2'(rd_inflight) - 2'(fire);
  assign rd_issue  = (d_state != D_IDLE) && (32'(rd_ptr) < NPIX) && (held_next <= 2'd1);
  assign b_raddr   = dump_start ? {bank, {PAW{1'b0}}} : {d_bank, rd_ptr[PAW-1:0]};
  assign rd_word   = WORDW'(ram_b_rdata);
  assign load_out  = fire || !out_valid;

  assign busy = (acc_state == ACC_RUN) || (d_state != D_IDLE);
  assign dbg  = '{acc: acc_state, dmp: d_state, bank: bank};

  spad_accum_ram #(
    .DEPTH(2 * NPIX),
    .W    (SUMW),
    .AW   (RAW)
  ) u_ram (
    .clk    (clk),
    .a_we   (wr_pend),
    .a_waddr({bank, wr_addr}),
    .a_wdata(wr_sum),
    .a_raddr({bank, pix_idx}),
    .a_rdata(ram_a_rdata),
    .b_raddr(b_raddr),
    .b_rdata(ram_b_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state  <= ACC_IDLE;
      bank       <= 1'b0;
      exp_addr   <= '0;
      frame_cnt  <= '0;
      n_lat      <= 8'd1;
      mask_q     <= '0;
      prev_valid <= 1'b0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      wr_cnt     <= '0;
      wr_first   <= 1'b0;
      wr_last    <= 1'b0;
    end else begin
      prev_valid <= pix_valid;
      if (mask_we) mask_q[mask_addr] <= mask_bit;
      wr_pend <= pix_take;
      if (pix_take) begin
        wr_addr  <= pix_idx;
        wr_cnt   <= mask_q[pix_idx] ? 5'd0 : pix_cnt;
        wr_first <= (frame_cnt == 8'd0);
        wr_last  <= (32'(pix_idx) == NPIX - 1);
        exp_addr <= (32'(pix_idx) == NPIX - 1) ? '0 : pix_idx + 1'b1;
      end
      if (wr_pend && wr_last) begin
        if (set_done) begin
          frame_cnt <= 8'd0;
          n_lat     <= n_eff;
          if (dmp_free) bank <= ~bank;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
      case (acc_state)
        ACC_IDLE: if (en) begin
          acc_state <= ACC_RUN;
          exp_addr  <= '0;
          frame_cnt <= 8'd0;
          n_lat     <= n_eff;
        end
        ACC_RUN: if (!en) acc_state <= ACC_IDLE;
        default: acc_state <= ACC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
      ovf_err <= 1'b0;
    end else if (clr_err) begin
      seq_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (pix_bad) seq_err <= 1'b1;
      if (set_drop) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state     <= D_IDLE;
      d_bank      <= 1'b0;
      rd_ptr      <= '0;
      tx_cnt      <= '0;
      rd_inflight <= 1'b0;
      pf_valid    <= 1'b0;
      pf_data     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      set_cnt     <= '0;
    end else begin
      rd_inflight <= rd_issue || dump_start;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      if (fire && (d_state == D_DATA)) tx_cnt <= tx_cnt + 1'b1;
      if (load_out) begin
        if (pf_valid) begin
          out_data  <= pf_data;
          out_valid <= 1'b1;
          pf_valid  <= rd_inflight;
          if (rd_inflight) pf_data <= rd_word;
        end else if (rd_inflight) begin
          out_data  <= rd_word;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_inflight) begin
        pf_data  <= rd_word;
        pf_valid <= 1'b1;
      end
      case (d_state)
        D_HDR:   if (fire) d_state <= D_DATA;
        D_DATA:  if (dump_done) d_state <= D_IDLE;
        default: d_state <= D_IDLE;
      endcase
      // Header is loaded directly; word 0 is already being read this cycle
      if (dump_start) begin
        d_state   <= D_HDR;
        d_bank    <= bank;
        rd_ptr    <= (PAW + 1)'(1);
        tx_cnt    <= '0;
        out_data  <= {HDR_TAG, set_cnt};
        out_valid <= 1'b1;
        set_cnt   <= set_cnt + 1'b1;
      end
    end
  end

endmodule
